// File: rtl/soc_system_sysid_ext.sv
// System-ID / build-info Avalon-MM slave: ID, timestamp, build info, scratch, uptime and caps words.
// Uptime counter, prescaler and snapshot are built only when SOC_SYSID_UPTIME_EN is defined.
module soc_system_sysid_ext #(
  parameter logic [31:0] ID_VALUE     = 32'hACD51302,
  parameter logic [31:0] TIMESTAMP    = 32'h55F060DF,
  parameter logic [31:0] BUILD_INFO   = 32'h00000000,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned UPTIME_DIV   = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  output logic        readdatavalid
);

`ifdef SOC_SYSID_UPTIME_EN
  localparam bit UPTIME_EN = 1'b1;
`else
  localparam bit UPTIME_EN = 1'b0;
`endif

  localparam logic [2:0]  CAPS_LAT = 3'(READ_LATENCY);
  localparam logic [15:0] CAPS_DIV = UPTIME_EN ? 16'(UPTIME_DIV) : 16'h0000;
  localparam logic [31:0] CAPS     = {12'h000, CAPS_DIV, UPTIME_EN, CAPS_LAT};

  logic        rd_accept;
  logic [31:0] scratch;
  logic [31:0] up_lo;
  logic [31:0] up_snap;
  logic [31:0] rd_mux;

  // A simultaneous write wins; the read is dropped without a response.
  assign rd_accept = read & ~write;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scratch <= '0;
    end else if (write && address == 3'd3) begin
      for (int b = 0; b < 4; b++) begin
        if (byteenable[b]) scratch[8*b +: 8] <= writedata[8*b +: 8];
      end
    end
  end

`ifdef SOC_SYSID_UPTIME_EN
  localparam logic [15:0] PRE_MAX = 16'(UPTIME_DIV - 1);

  logic [63:0] uptime;
  logic [15:0] prescale;
  logic [31:0] snapshot;
  logic        up_clr;

  assign up_clr = write && address == 3'd4;

  // LO read latches the high word so a later HI read is coherent across a carry.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      uptime   <= '0;
      prescale <= '0;
      snapshot <= '0;
    end else if (up_clr) begin
      uptime   <= '0;
      prescale <= '0;
      snapshot <= '0;
    end else begin
      if (prescale == PRE_MAX) begin
        prescale <= '0;
        uptime   <= uptime + 64'd1;
      end else begin
        prescale <= prescale + 16'd1;
      end
      if (rd_accept && address == 3'd4) snapshot <= uptime[63:32];
    end
  end

  assign up_lo   = uptime[31:0];
  assign up_snap = snapshot;
`else
  assign up_lo   = '0;
  assign up_snap = '0;
`endif

  always_comb begin
    rd_mux = '0;
    case (address)
      3'd0:    rd_mux = ID_VALUE;
      3'd1:    rd_mux = TIMESTAMP;
      3'd2:    rd_mux = BUILD_INFO;
      3'd3:    rd_mux = scratch;
      3'd4:    rd_mux = up_lo;
      3'd5:    rd_mux = up_snap;
      3'd6:    rd_mux = CAPS;
      default: rd_mux = '0;
    endcase
  end

  logic [31:0] data_p [READ_LATENCY];
  logic        vld_p  [READ_LATENCY];

  // Stage 0 captures the accepted read; data is zeroed when not valid so readdata idles at 0.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        data_p[i] <= '0;
        vld_p[i]  <= 1'b0;
      end
    end else begin
      data_p[0] <= rd_accept ? rd_mux : '0;
      vld_p[0]  <= rd_accept;
      for (int i = 1; i < READ_LATENCY; i++) begin
        data_p[i] <= data_p[i-1];
        vld_p[i]  <= vld_p[i-1];
      end
    end
  end

  // Output stage
  assign readdata      = data_p[READ_LATENCY-1];
  assign readdatavalid = vld_p[READ_LATENCY-1];

endmodule
